// File: rtl/obj_pos_ctrl_if.sv
// Handshake bundle between the frame/button source and the object position controller.
// The master drives frame_tick, buttons and mode; the slave returns position and status.
interface obj_pos_ctrl_if #(
  parameter int POS_W = 12
);
  logic                    frame_tick;
  logic                    btn_l;
  logic                    btn_r;
  logic                    btn_u;
  logic                    btn_d;
  logic                    mode_auto;
  logic signed [POS_W-1:0] x_pos;
  logic signed [POS_W-1:0] y_pos;
  logic                    hit_edge;
  logic                    moving;

  modport master (
    output frame_tick, btn_l, btn_r, btn_u, btn_d, mode_auto,
    input  x_pos, y_pos, hit_edge, moving
  );

  modport slave (
    input  frame_tick, btn_l, btn_r, btn_u, btn_d, mode_auto,
    output x_pos, y_pos, hit_edge, moving
  );
endinterface

// File: rtl/obj_pos_ctrl.sv
// Frame-synchronous position controller for one on-screen object: button moves with
// hold-to-repeat and edge clamping; define OBJ_POS_AUTO_EN to add the bouncing auto mode.
module obj_pos_ctrl #(
  parameter int H_RES    = 1920,
  parameter int V_RES    = 1080,
  parameter int HALF_W   = 120,
  parameter int HALF_H   = 120,
  parameter int STEP     = 20,
  parameter int X_INIT   = 960,
  parameter int Y_INIT   = 540,
  parameter int REP_DLY  = 24,
  parameter int REP_RATE = 4,
  parameter int POS_W    = 12
) (
  input logic           clk_148Mhz,
  input logic           reset,
  obj_pos_ctrl_if.slave bus
);

  localparam int CNT_MAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic signed [POS_W:0] wide_t;
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rep_state_e;

  // Index 0 is the X axis, index 1 the Y axis.
  localparam wide_t LIM_LO [2] = '{wide_t'(HALF_W), wide_t'(HALF_H)};
  localparam wide_t LIM_HI [2] = '{wide_t'(H_RES - 1 - HALF_W), wide_t'(V_RES - 1 - HALF_H)};
  localparam wide_t STEP_W     = wide_t'(STEP);

  rep_state_e              state_q  [2];
  rep_state_e              state_d  [2];
  logic [CNT_W-1:0]        cnt_q    [2];
  logic [CNT_W-1:0]        cnt_d    [2];
  logic                    neg_q    [2];  // direction latched at press: 1 = left/up
  logic                    neg_d    [2];
  logic signed [POS_W-1:0] pos_q    [2];
  logic signed [POS_W-1:0] pos_d    [2];
  logic                    btn_pos  [2];
  logic                    btn_neg  [2];
  logic                    do_move  [2];
  logic                    move_neg [2];
  wide_t                   nxt      [2];
  logic                    hit_q, hit_d;
  logic                    moving_q, moving_d;
  logic                    auto_on;

  assign btn_pos[0] = bus.btn_r;
  assign btn_neg[0] = bus.btn_l;
  assign btn_pos[1] = bus.btn_d;
  assign btn_neg[1] = bus.btn_u;

`ifdef OBJ_POS_AUTO_EN
  logic dneg_q [2];
  logic dneg_d [2];
  assign auto_on = bus.mode_auto;
`else
  assign auto_on = 1'b0;
`endif

  // NOTE: every output of this block gets a default before any branch, so no latches are inferred.
  always_comb begin
    hit_d    = 1'b0;
    moving_d = bus.frame_tick ? 1'b0 : moving_q;
    for (int a = 0; a < 2; a++) begin
      state_d[a]  = state_q[a];
      cnt_d[a]    = cnt_q[a];
      neg_d[a]    = neg_q[a];
      pos_d[a]    = pos_q[a];
      do_move[a]  = 1'b0;
      move_neg[a] = 1'b0;
      nxt[a]      = '0;
`ifdef OBJ_POS_AUTO_EN
      dneg_d[a]   = dneg_q[a];
`endif
      if (bus.frame_tick) begin
        if (auto_on) begin
          state_d[a] = S_IDLE;
          cnt_d[a]   = '0;
          do_move[a] = 1'b1;
`ifdef OBJ_POS_AUTO_EN
          move_neg[a] = dneg_q[a];
`endif
          if (btn_pos[a] && !btn_neg[a])      move_neg[a] = 1'b0;
          else if (btn_neg[a] && !btn_pos[a]) move_neg[a] = 1'b1;
        end else begin
          unique case (state_q[a])
            S_IDLE: begin
              if (btn_pos[a] ^ btn_neg[a]) begin
                do_move[a]  = 1'b1;
                move_neg[a] = btn_neg[a];
                neg_d[a]    = btn_neg[a];
                cnt_d[a]    = CNT_W'(REP_DLY);
                state_d[a]  = S_DELAY;
              end
            end
            default: begin
              // Release, both held, or a reversed direction all restart from a fresh press.
              if (!(btn_pos[a] ^ btn_neg[a]) || (btn_neg[a] != neg_q[a])) begin
                state_d[a] = S_IDLE;
                cnt_d[a]   = '0;
              end else if (cnt_q[a] == CNT_W'(1)) begin
                do_move[a]  = 1'b1;
                move_neg[a] = neg_q[a];
                cnt_d[a]    = CNT_W'(REP_RATE);
                state_d[a]  = S_REPEAT;
              end else begin
                cnt_d[a] = cnt_q[a] - CNT_W'(1);
              end
            end
          endcase
        end

        if (do_move[a]) begin
          nxt[a] = move_neg[a] ? (wide_t'(pos_q[a]) - STEP_W) : (wide_t'(pos_q[a]) + STEP_W);
`ifdef OBJ_POS_AUTO_EN
          if (auto_on) dneg_d[a] = move_neg[a];
`endif
          // Auto mode reflects on reaching a limit; manual mode only clamps on crossing it.
          if ((nxt[a] > LIM_HI[a]) || (auto_on && (nxt[a] == LIM_HI[a]))) begin
            pos_d[a] = LIM_HI[a][POS_W-1:0];
            hit_d    = 1'b1;
`ifdef OBJ_POS_AUTO_EN
            if (auto_on) dneg_d[a] = 1'b1;
`endif
          end else if ((nxt[a] < LIM_LO[a]) || (auto_on && (nxt[a] == LIM_LO[a]))) begin
            pos_d[a] = LIM_LO[a][POS_W-1:0];
            hit_d    = 1'b1;
`ifdef OBJ_POS_AUTO_EN
            if (auto_on) dneg_d[a] = 1'b0;
`endif
          end else begin
            pos_d[a] = nxt[a][POS_W-1:0];
          end
        end

        if (pos_d[a] != pos_q[a]) moving_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= S_IDLE;
        cnt_q[a]   <= '0;
        neg_q[a]   <= 1'b0;
`ifdef OBJ_POS_AUTO_EN
        dneg_q[a]  <= 1'b0;
`endif
      end
      pos_q[0] <= POS_W'(X_INIT);
      pos_q[1] <= POS_W'(Y_INIT);
      hit_q    <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= state_d[a];
        cnt_q[a]   <= cnt_d[a];
        neg_q[a]   <= neg_d[a];
        pos_q[a]   <= pos_d[a];
`ifdef OBJ_POS_AUTO_EN
        dneg_q[a]  <= dneg_d[a];
`endif
      end
      hit_q    <= hit_d;
      moving_q <= moving_d;
    end
  end

  assign bus.x_pos    = pos_q[0];
  assign bus.y_pos    = pos_q[1];
  assign bus.hit_edge = hit_q;
  assign bus.moving   = moving_q;

endmodule

// File: tb/tb_obj_pos_ctrl.sv
// Directed testbench for obj_pos_ctrl with hand-computed positions for default parameters.
// The auto-bounce section only runs when OBJ_POS_AUTO_EN is defined.
module tb_obj_pos_ctrl;
  logic clk_148Mhz = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic hit_now;
  logic hit_any;
  logic hit_stuck;
  int   xs [1:40];

  obj_pos_ctrl_if #(.POS_W(12)) bus ();

  obj_pos_ctrl dut (
    .clk_148Mhz (clk_148Mhz),
    .reset      (reset),
    .bus        (bus)
  );

  always #3 clk_148Mhz = ~clk_148Mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: tick pulse, sample outputs the cycle after, confirm hit_edge dropped a cycle later.
  task automatic tick();
    @(negedge clk_148Mhz);
    bus.frame_tick = 1'b1;
    @(negedge clk_148Mhz);
    bus.frame_tick = 1'b0;
    hit_now = bus.hit_edge;
    if (hit_now) hit_any = 1'b1;
    @(negedge clk_148Mhz);
    if (bus.hit_edge) hit_stuck = 1'b1;
    @(negedge clk_148Mhz);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Press-and-release taps: which = 0 -> btn_r, 1 -> btn_d.
  task automatic tap(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) bus.btn_r = 1'b1; else bus.btn_d = 1'b1;
      tick();
      bus.btn_r = 1'b0;
      bus.btn_d = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.btn_l      = 1'b0;
    bus.btn_r      = 1'b0;
    bus.btn_u      = 1'b0;
    bus.btn_d      = 1'b0;
    bus.mode_auto  = 1'b0;
    hit_now        = 1'b0;
    hit_any        = 1'b0;
    hit_stuck      = 1'b0;
    repeat (3) @(negedge clk_148Mhz);
    check("rst_x", bus.x_pos, 960);
    check("rst_y", bus.y_pos, 540);
    check("rst_hit", bus.hit_edge, 0);
    check("rst_moving", bus.moving, 0);
    reset = 1'b0;

    // Idle frames
    ticks(10);
    check("idle_x", bus.x_pos, 960);
    check("idle_y", bus.y_pos, 540);
    check("idle_moving", bus.moving, 0);
    check("idle_hit_any", hit_any, 0);

    // Hold right for 40 frames: moves on ticks 1, 25, 29, 33, 37
    bus.btn_r = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      xs[i] = int'(bus.x_pos);
      if (i == 37) check("hold_moving_t37", bus.moving, 1);
    end
    check("hold_x_t1", xs[1], 980);
    check("hold_x_t24", xs[24], 980);
    check("hold_x_t25", xs[25], 1000);
    check("hold_x_t28", xs[28], 1000);
    check("hold_x_t29", xs[29], 1020);
    check("hold_x_t33", xs[33], 1040);
    check("hold_x_t40", xs[40], 1060);
    check("hold_moving_t40", bus.moving, 0);

    // Opposite buttons together: no movement, then left alone moves immediately
    bus.btn_l = 1'b1;
    ticks(30);
    check("both_x", bus.x_pos, 1060);
    check("both_moving", bus.moving, 0);
    bus.btn_r = 1'b0;
    tick();
    check("left_x", bus.x_pos, 1040);
    check("left_moving", bus.moving, 1);
    bus.btn_l = 1'b0;
    tick();

    // Walk to x=1780 then clamp at XMAX=1799
    tap(0, 37);
    check("walk_x", bus.x_pos, 1780);
    hit_any = 1'b0;
    bus.btn_r = 1'b1;
    tick();
    check("clamp_x", bus.x_pos, 1799);
    check("clamp_hit", hit_now, 1);
    check("clamp_moving", bus.moving, 1);
    ticks(23);
    check("clamp_hit_t24", hit_now, 0);
    tick();
    check("clamp_rep_x", bus.x_pos, 1799);
    check("clamp_rep_hit", hit_now, 1);
    check("clamp_rep_moving", bus.moving, 0);
    bus.btn_r = 1'b0;
    tick();

    // Walk down to y=900
    tap(1, 18);
    check("walk_y", bus.y_pos, 900);

`ifdef OBJ_POS_AUTO_EN
    // Bounce on Y while left button forces X direction
    bus.mode_auto = 1'b1;
    bus.btn_l     = 1'b1;
    tick();
    check("auto_y1", bus.y_pos, 920);
    check("auto_hit1", hit_now, 0);
    tick();
    check("auto_y2", bus.y_pos, 940);
    tick();
    check("auto_y3", bus.y_pos, 959);
    check("auto_hit3", hit_now, 1);
    tick();
    check("auto_y4", bus.y_pos, 939);
    check("auto_hit4", hit_now, 0);
    check("auto_x4", bus.x_pos, 1719);
    bus.mode_auto = 1'b0;
    bus.btn_l     = 1'b0;
    tick();
    check("manual_back_y", bus.y_pos, 939);
`else
    // mode_auto is ignored: left press moves once then waits for the repeat delay
    hit_any       = 1'b0;
    bus.mode_auto = 1'b1;
    bus.btn_l     = 1'b1;
    ticks(4);
    check("noauto_x", bus.x_pos, 1779);
    check("noauto_y", bus.y_pos, 900);
    check("noauto_hit_any", hit_any, 0);
    bus.mode_auto = 1'b0;
    bus.btn_l     = 1'b0;
    tick();
`endif

    // Reset in the middle of a repeat with btn_d held
    bus.btn_d = 1'b1;
    ticks(30);
    repeat (2) @(negedge clk_148Mhz);
    reset = 1'b1;
    @(negedge clk_148Mhz);
    check("mid_rst_x", bus.x_pos, 960);
    check("mid_rst_y", bus.y_pos, 540);
    check("mid_rst_moving", bus.moving, 0);
    @(negedge clk_148Mhz);
    reset = 1'b0;
    repeat (2) @(negedge clk_148Mhz);
    check("post_rst_y", bus.y_pos, 540);
    tick();
    check("post_rst_y_t1", bus.y_pos, 560);
    repeat (5) @(negedge clk_148Mhz);
    check("moving_holds", bus.moving, 1);
    ticks(23);
    check("post_rst_y_t24", bus.y_pos, 560);
    tick();
    check("post_rst_y_t25", bus.y_pos, 580);
    bus.btn_d = 1'b0;
    tick();

    check("hit_one_cycle", hit_stuck, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
